matmul_engine: RTL and testbench
================================

MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data, product and accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning data-memory address width.
REQ-003 SHALL have parameter DIM_W, default 4, meaning width of each matrix dimension field.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  request to begin C = A x B.
REQ-007 SHALL have ports dimM, dimK, dimN  input  DIM_W each  giving A as M x K, B as K x N and C as M x N.
REQ-008 SHALL have ports baseA, baseB, baseC  input  ADDR_W each  giving the row-major matrix base addresses.
REQ-009 SHALL have port mem_rdata  input  WIDTH  read data, valid in the cycle after mem_read is asserted.
REQ-010 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-011 SHALL have ports mem_read and mem_write  output  1 each  memory strobes; at most one is high in any cycle.
REQ-012 SHALL have port mem_wdata  output  WIDTH  write data.
REQ-013 SHALL have port busy  output  1  high while in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RDA, RDB, MAC, WRC and DONE.
REQ-016 SHALL sample start only in IDLE; on start=1 it SHALL latch all dims and bases, clear i, j, k and acc, and go to RDA. If any dim is 0, it SHALL instead go directly to DONE with no memory access.
REQ-017 SHALL ignore start in every non-IDLE state; the latched operands SHALL be unaffected by input changes during operation.
REQ-018 RDA: SHALL assert mem_read=1 with mem_addr = baseA + i*K + k; next state RDB.
REQ-019 RDB: SHALL capture mem_rdata into an A operand register; SHALL assert mem_read=1 with mem_addr = baseB + k*N + j; next state MAC.
REQ-020 MAC: SHALL set acc <= acc + Areg*mem_rdata, truncated modulo 2^WIDTH. If k = K-1, next state is WRC; otherwise k increments and next state is RDA.
REQ-021 WRC: SHALL assert mem_write=1 with mem_addr = baseC + i*N + j and mem_wdata = acc. It SHALL then clear acc and k.
REQ-022 WRC loop advance: if j < N-1, j increments; otherwise j clears and i increments. If the element written was (M-1, N-1), next state is DONE; otherwise RDA.
REQ-023 DONE: SHALL assert done=1 for exactly one cycle; next state IDLE.
REQ-024 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-025 Total cycles from the start-sampling edge to the done pulse SHALL be M*N*(3K+1)+1.
REQ-026 When the strobes are low, mem_addr and mem_wdata SHALL be 0.
REQ-027 The done pulse SHALL coincide with busy=1; busy SHALL be 0 in the following cycle.

Reset
REQ-028 Rst_n=0 SHALL immediately force: state IDLE; i, j, k, acc and operand registers to 0; mem_read, mem_write, busy and done to 0; mem_addr and mem_wdata to 0.
REQ-029 Reset mid-operation SHALL abort without completing any pending write and without a done pulse; the first start after Rst_n rises SHALL run a full fresh computation.

Verification
REQ-030 M=K=N=1, bases 0x00/0x10/0x20, A=3, B=4 -> read 0x00, read 0x10, write 12 to 0x20, done in the 5th cycle after start.
REQ-031 M=K=N=2, A=[1 2;3 4], B=identity -> writes 1,2,3,4 to baseC..baseC+3 in that order, done after 29 cycles.
REQ-032 WIDTH=8, M=N=1, K=2, A=[16 1], B=[16 1] -> 256+1 wraps, writes 0x01.
REQ-033 dimK=0 with start=1 -> no mem_read or mem_write, done in the next cycle.
REQ-034 Rst_n pulsed low during the 2x2 run, then restarted -> no done from the aborted run, no write after the reset edge, restart gives correct results.
REQ-035 start held high and dims changed while busy -> results reflect the latched dims, with exactly one done per IDLE-sampled start.

Source files
------------

// File: rtl/matmul_engine.sv
// Sequential C = A x B engine over a single-port data memory; one MAC per three cycles.
// Operand dims and base addresses are latched at start so the inputs may change freely during a run.
module matmul_engine #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  dimM,
  input  logic [DIM_W-1:0]  dimK,
  input  logic [DIM_W-1:0]  dimN,
  input  logic [ADDR_W-1:0] baseA,
  input  logic [ADDR_W-1:0] baseB,
  input  logic [ADDR_W-1:0] baseC,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, MAC, WRC, DONE} state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [ADDR_W-1:0]   base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic [DIM_W-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0]    acc_q, acc_d, a_q, a_d;

  // Full-width index products, then wrapped into the address space.
  logic [2*DIM_W-1:0]  ik_prod, kn_prod, in_prod;
  logic [ADDR_W-1:0]   addr_a, addr_b, addr_c;
  logic                k_last, j_last, i_last;

  assign ik_prod = {{DIM_W{1'b0}}, i_q} * {{DIM_W{1'b0}}, dim_k_q};
  assign kn_prod = {{DIM_W{1'b0}}, k_q} * {{DIM_W{1'b0}}, dim_n_q};
  assign in_prod = {{DIM_W{1'b0}}, i_q} * {{DIM_W{1'b0}}, dim_n_q};
  assign addr_a  = base_a_q + ADDR_W'(ik_prod) + ADDR_W'(k_q);
  assign addr_b  = base_b_q + ADDR_W'(kn_prod) + ADDR_W'(j_q);
  assign addr_c  = base_c_q + ADDR_W'(in_prod) + ADDR_W'(j_q);
  assign k_last  = (k_q == dim_k_q - DIM_W'(1));
  assign j_last  = (j_q == dim_n_q - DIM_W'(1));
  assign i_last  = (i_q == dim_m_q - DIM_W'(1));

  always_comb begin
    state_d   = state_q;
    dim_m_d   = dim_m_q;
    dim_k_d   = dim_k_q;
    dim_n_d   = dim_n_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    base_c_d  = base_c_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    a_d       = a_q;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dim_m_d  = dimM;
          dim_k_d  = dimK;
          dim_n_d  = dimN;
          base_a_d = baseA;
          base_b_d = baseB;
          base_c_d = baseC;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          acc_d    = '0;
          state_d  = (dimM == '0 || dimK == '0 || dimN == '0) ? DONE : RDA;
        end
      end
      RDA: begin
        mem_read = 1'b1;
        mem_addr = addr_a;
        state_d  = RDB;
      end
      RDB: begin
        a_d      = mem_rdata;
        mem_read = 1'b1;
        mem_addr = addr_b;
        state_d  = MAC;
      end
      MAC: begin
        acc_d = acc_q + a_q * mem_rdata;
        if (k_last) begin
          state_d = WRC;
        end else begin
          k_d     = k_q + DIM_W'(1);
          state_d = RDA;
        end
      end
      WRC: begin
        mem_write = 1'b1;
        mem_addr  = addr_c;
        mem_wdata = acc_q;
        acc_d     = '0;
        k_d       = '0;
        if (j_last) begin
          j_d = '0;
          i_d = i_q + DIM_W'(1);
        end else begin
          j_d = j_q + DIM_W'(1);
        end
        state_d = (i_last && j_last) ? DONE : RDA;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_n_q  <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      a_q      <= '0;
    end else begin
      state_q  <= state_d;
      dim_m_q  <= dim_m_d;
      dim_k_q  <= dim_k_d;
      dim_n_q  <= dim_n_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: a one-cycle-latency memory model, a bus monitor and hand-computed results.
module tb_matmul_engine;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dimM = '0, dimK = '0, dimN = '0;
  logic [7:0] baseA = '0, baseB = '0, baseC = '0;
  logic [7:0] mem_rdata = '0;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_read, mem_write, busy, done;

  matmul_engine #(.WIDTH(8), .ADDR_W(8), .DIM_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start),
    .dimM(dimM), .dimK(dimK), .dimN(dimN),
    .baseA(baseA), .baseB(baseB), .baseC(baseC),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0, n_total = 0;
  int done_cnt = 0, viol = 0;
  logic [7:0] mem [256];
  logic [7:0] rd_q[$], wa_q[$], wd_q[$];

  always @(posedge Clk) mem_rdata <= mem_read ? mem[mem_addr] : 8'h00;

  always @(negedge Clk) begin
    if (mem_read) rd_q.push_back(mem_addr);
    if (mem_write) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (mem_read && mem_write) viol++;
    if (!mem_read && !mem_write && (mem_addr != 8'h00 || mem_wdata != 8'h00)) viol++;
    if (done) begin
      done_cnt++;
      if (!busy) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    else n_pass++;
  endtask

  task automatic clear_log();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_wr(input int idx, input logic [7:0] a, input logic [7:0] d);
    check("wr_addr", (idx < wa_q.size()) ? wa_q[idx] : 8'hxx, a);
    check("wr_data", (idx < wd_q.size()) ? wd_q[idx] : 8'hxx, d);
  endtask

  // lat counts cycles after the start-sampling edge up to and including the done cycle.
  task automatic run(input logic [3:0] m, input logic [3:0] k, input logic [3:0] n,
                     input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bc,
                     input bit hold, output int lat);
    @(negedge Clk);
    dimM = m; dimK = k; dimN = n; baseA = ba; baseB = bb; baseC = bc; start = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
      if (lat == 1) begin
        if (hold) begin
          dimM = 4'd2; dimK = 4'd2; dimN = 4'd2;
          baseA = 8'hC0; baseB = 8'hC8; baseC = 8'hD0;
        end else start = 1'b0;
      end
    end while (!done && lat < 200);
    start = 1'b0;
    @(negedge Clk);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic check_2x2(input logic [7:0] bc);
    check("wr_count_2x2", wa_q.size(), 4);
    for (int e = 0; e < 4; e++) check_wr(e, bc + 8'(e), 8'(e + 1));
  endtask

  int lat, d0, wcnt;

  initial begin
    foreach (mem[a]) mem[a] = 8'h00;
    mem[8'h00] = 8'd3;  mem[8'h10] = 8'd4;
    mem[8'h40] = 8'd1;  mem[8'h41] = 8'd2;  mem[8'h42] = 8'd3;  mem[8'h43] = 8'd4;
    mem[8'h50] = 8'd1;  mem[8'h53] = 8'd1;
    for (int a = 0; a < 6; a++) mem[8'h70 + a] = 8'(a + 1);
    mem[8'h78] = 8'd7;  mem[8'h79] = 8'd8;  mem[8'h7A] = 8'd9;
    mem[8'h90] = 8'd16; mem[8'h91] = 8'd1;  mem[8'hA0] = 8'd16; mem[8'hA1] = 8'd1;
    mem[8'hFE] = 8'd5;  mem[8'hFF] = 8'd2;

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read", mem_read, 1'b0);
    check("rst_write", mem_write, 1'b0);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_wdata", mem_wdata, 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1;

    // 1x1x1: 3*4
    clear_log(); d0 = done_cnt;
    run(4'd1, 4'd1, 4'd1, 8'h00, 8'h10, 8'h20, 1'b0, lat);
    check("lat_1x1x1", lat, 5);
    check("rd_count_1x1x1", rd_q.size(), 2);
    check("rd0_1x1x1", (rd_q.size() > 0) ? rd_q[0] : 8'hxx, 8'h00);
    check("rd1_1x1x1", (rd_q.size() > 1) ? rd_q[1] : 8'hxx, 8'h10);
    check("wr_count_1x1x1", wa_q.size(), 1);
    check_wr(0, 8'h20, 8'd12);
    check("done_1x1x1", done_cnt - d0, 1);

    // 2x2 times identity
    clear_log();
    run(4'd2, 4'd2, 4'd2, 8'h40, 8'h50, 8'h60, 1'b0, lat);
    check("lat_2x2x2", lat, 29);
    check_2x2(8'h60);

    // 2x3 times 3x1: [1 2 3;4 5 6]*[7;8;9] = [50;122]
    clear_log();
    run(4'd2, 4'd3, 4'd1, 8'h70, 8'h78, 8'h7E, 1'b0, lat);
    check("lat_2x3x1", lat, 21);
    check("wr_count_2x3x1", wa_q.size(), 2);
    check_wr(0, 8'h7E, 8'd50);
    check_wr(1, 8'h7F, 8'd122);

    // 16*16 + 1*1 wraps to 1
    clear_log();
    run(4'd1, 4'd2, 4'd1, 8'h90, 8'hA0, 8'hB0, 1'b0, lat);
    check("lat_wrap_acc", lat, 8);
    check("wr_count_wrap_acc", wa_q.size(), 1);
    check_wr(0, 8'hB0, 8'd1);

    // address wrap: B row spans 0xFF,0x00; C spans 0xFF,0x00
    clear_log();
    run(4'd1, 4'd1, 4'd2, 8'hFE, 8'hFF, 8'hFF, 1'b0, lat);
    check("lat_addr_wrap", lat, 9);
    check("rd_b1_addr_wrap", (rd_q.size() > 3) ? rd_q[3] : 8'hxx, 8'h00);
    check("wr_count_addr_wrap", wa_q.size(), 2);
    check_wr(0, 8'hFF, 8'd10);
    check_wr(1, 8'h00, 8'd15);

    // zero dimension
    clear_log(); d0 = done_cnt;
    run(4'd2, 4'd0, 4'd2, 8'h40, 8'h50, 8'h60, 1'b0, lat);
    check("lat_dimk0", lat, 1);
    check("rd_count_dimk0", rd_q.size(), 0);
    check("wr_count_dimk0", wa_q.size(), 0);
    check("done_dimk0", done_cnt - d0, 1);

    // abort a 2x2 run in its second element's RDB cycle
    clear_log(); d0 = done_cnt;
    @(negedge Clk);
    dimM = 4'd2; dimK = 4'd2; dimN = 4'd2; baseA = 8'h40; baseB = 8'h50; baseC = 8'h60; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (8) @(negedge Clk);
    wcnt = wa_q.size();
    check("abort_pre_writes", wcnt, 1);
    #2 Rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_read", mem_read, 1'b0);
    check("abort_addr", mem_addr, 8'h00);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("abort_no_write", wa_q.size(), wcnt);
    check("abort_no_done", done_cnt - d0, 0);
    clear_log();
    run(4'd2, 4'd2, 4'd2, 8'h40, 8'h50, 8'h60, 1'b0, lat);
    check("lat_restart", lat, 29);
    check_2x2(8'h60);

    // start held high, operands changed while busy
    clear_log(); d0 = done_cnt;
    run(4'd1, 4'd1, 4'd1, 8'h00, 8'h10, 8'h20, 1'b1, lat);
    check("lat_hold", lat, 5);
    repeat (4) @(negedge Clk);
    check("hold_idle", busy, 1'b0);
    check("wr_count_hold", wa_q.size(), 1);
    check_wr(0, 8'h20, 8'd12);
    check("done_hold", done_cnt - d0, 1);

    check("bus_violations", viol, 0);
    check("done_total", done_cnt, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
